// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - register map, requester ids and access record for the shared register bank
package regbank_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  localparam int REG_PWM0    = 0;
  localparam int REG_PWM1    = 1;
  localparam int REG_LED     = 2;
  localparam int REG_UARTCFG = 3;

  localparam int REQ_I2C  = 0;
  localparam int REQ_PAR  = 1;
  localparam int REQ_UART = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_RESP = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/regbank_rr_arbiter.sv
// rtl/regbank_rr_arbiter.sv - combinational round-robin pick: first unmasked request at or above ptr
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [NREQ-1:0] w_elig;
  int              w_cand;

  always_comb begin
    w_elig = req & ~mask;
    gnt    = '0;
    idx    = '0;
    valid  = 1'b0;
    w_cand = 0;
    for (int off = 0; off < NREQ; off++) begin
      // ptr never exceeds NREQ-1, so one subtraction is enough to wrap
      w_cand = int'(ptr) + off;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!valid && w_elig[w_cand]) begin
        valid       = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = PW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - round-robin shared register bank with registered grant, write commit and read response
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int             NREQ      = 3,
  parameter int             DW        = DATA_W,
  parameter int             AW        = ADDR_W,
  parameter int             REGS      = 4,
  parameter logic [DW-1:0]  RESET_VAL = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic [REGS*DW-1:0]   regs_flat,
  output logic [REGS-1:0]      reg_upd
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  pipe_state_t     r_state;
  pipe_state_t     w_next_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic [REGS-1:0] r_upd;
  logic [DW-1:0]   r_regs [REGS];
  acc_t            r_acc;

  logic [NREQ-1:0] w_win;
  logic [PW-1:0]   w_win_idx;
  logic            w_win_valid;
  acc_t            w_win_acc;
  logic            w_commit;
  logic            w_resp;
  logic [DW-1:0]   w_rd_data;

  // The requester granted last edge still holds req for one more edge; masking it prevents a double grant
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (req),
    .mask  (r_gnt),
    .ptr   (r_ptr),
    .gnt   (w_win),
    .idx   (w_win_idx),
    .valid (w_win_valid)
  );

  always_comb begin
    w_win_acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_idx == PW'(i)) begin
        w_win_acc.we    = we[i];
        w_win_acc.addr  = addr[i*AW +: AW];
        w_win_acc.wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int r = 0; r < REGS; r++) begin
      if (r_acc.addr == AW'(r)) w_rd_data = r_regs[r];
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    w_commit     = 1'b0;
    w_resp       = 1'b0;
    if (r_state == ST_GNT) begin
      w_commit = r_acc.we;
      w_resp   = !r_acc.we;
    end
    if (w_win_valid) w_next_state = ST_GNT;
    else if (w_resp) w_next_state = ST_RESP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_upd    <= '0;
      r_acc    <= '0;
      for (int r = 0; r < REGS; r++) r_regs[r] <= RESET_VAL;
    end else begin
      r_state  <= w_next_state;
      r_gnt    <= w_win;
      r_rvalid <= w_resp ? r_gnt : '0;
      if (w_resp) r_rdata <= w_rd_data;
      if (w_win_valid) begin
        r_ptr <= (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
        r_acc <= w_win_acc;
      end
      r_upd <= '0;
      // Unmapped addresses match no slot, so the write and its update pulse vanish
      for (int r = 0; r < REGS; r++) begin
        if (w_commit && r_acc.addr == AW'(r)) begin
          r_regs[r] <= r_acc.wdata;
          r_upd[r]  <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < REGS; g++) begin : g_flat
    assign regs_flat[g*DW +: DW] = r_regs[g];
  end

  assign gnt     = r_gnt;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign reg_upd = r_upd;

endmodule
